// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: per-stage trace FIFOs drained round-robin over one valid/ready port,
// with sticky overflow flags, a saturating drop counter and stop-on-ebreak capture.
module riscv_trace_buffer #(
  parameter int XLEN   = 64,
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 8,
  parameter int CNTW   = 16
) (
  input  logic                   i_riscv_clk,
  input  logic                   i_riscv_rst,
  input  logic                   i_riscv_trc_clear,
  input  logic                   i_riscv_trc_halt_en,
  input  logic [NUM_CH-1:0]      i_riscv_trc_valid,
  input  logic [NUM_CH*XLEN-1:0] i_riscv_trc_pc,
  input  logic [NUM_CH*32-1:0]   i_riscv_trc_instr,
  input  logic [NUM_CH-1:0]      i_riscv_trc_rd_we,
  input  logic [NUM_CH*5-1:0]    i_riscv_trc_rd_addr,
  input  logic [NUM_CH*XLEN-1:0] i_riscv_trc_rd_data,
  input  logic                   i_riscv_trc_ready,
  output logic                   o_riscv_trc_valid,
  output logic [2:0]             o_riscv_trc_ch,
  output logic [XLEN-1:0]        o_riscv_trc_pc,
  output logic [31:0]            o_riscv_trc_instr,
  output logic                   o_riscv_trc_rd_we,
  output logic [4:0]             o_riscv_trc_rd_addr,
  output logic [XLEN-1:0]        o_riscv_trc_rd_data,
  output logic [NUM_CH-1:0]      o_riscv_trc_ovf,
  output logic [CNTW-1:0]        o_riscv_trc_drop_cnt,
  output logic                   o_riscv_trc_halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  logic [XLEN-1:0] m_pc [NUM_CH][DEPTH];
  logic [31:0]     m_instr [NUM_CH][DEPTH];
  logic            m_we [NUM_CH][DEPTH];
  logic [4:0]      m_addr [NUM_CH][DEPTH];
  logic [XLEN-1:0] m_data [NUM_CH][DEPTH];
  logic [AW:0] wp [NUM_CH];
  logic [AW:0] rp [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, drop, hit;
  logic [2:0] rr, gnt, lock_ch, c, nxt;
  logic locked, found, pop;
  logic [AW-1:0] ra;
  logic [3:0] ndrop;
  logic [CNTW:0] cnt_sum;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign full[k]  = (wp[k][AW] != rp[k][AW]) && (wp[k][AW-1:0] == rp[k][AW-1:0]);
    assign empty[k] = wp[k] == rp[k];
    assign push[k]  = i_riscv_trc_valid[k] & ~o_riscv_trc_halted & ~full[k];
    assign drop[k]  = i_riscv_trc_valid[k] & ~o_riscv_trc_halted & full[k];
    assign hit[k]   = i_riscv_trc_valid[k] & (i_riscv_trc_instr[k*32 +: 32] == EBREAK);
  end
  // A locked grant overrides the scan so a stalled entry stays on the port until accepted.
  always_comb begin
    gnt = lock_ch;
    found = locked;
    c = rr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !empty[c]) begin
        gnt = c;
        found = 1'b1;
      end
      c = (c == 3'(NUM_CH - 1)) ? 3'd0 : c + 3'd1;
    end
  end
  always_comb begin
    ndrop = '0;
    for (int k = 0; k < NUM_CH; k++) ndrop = ndrop + 4'(drop[k]);
    cnt_sum = {1'b0, o_riscv_trc_drop_cnt} + (CNTW+1)'(ndrop);
  end
  assign nxt                 = (gnt == 3'(NUM_CH - 1)) ? 3'd0 : gnt + 3'd1;
  assign ra                  = rp[gnt][AW-1:0];
  assign o_riscv_trc_valid   = ~empty[gnt];
  assign pop                 = o_riscv_trc_valid & i_riscv_trc_ready;
  assign o_riscv_trc_ch      = o_riscv_trc_valid ? gnt : 3'd0;
  assign o_riscv_trc_pc      = o_riscv_trc_valid ? m_pc[gnt][ra] : '0;
  assign o_riscv_trc_instr   = o_riscv_trc_valid ? m_instr[gnt][ra] : '0;
  assign o_riscv_trc_rd_we   = o_riscv_trc_valid & m_we[gnt][ra];
  assign o_riscv_trc_rd_addr = o_riscv_trc_valid ? m_addr[gnt][ra] : '0;
  assign o_riscv_trc_rd_data = o_riscv_trc_valid ? m_data[gnt][ra] : '0;
  always_ff @(posedge i_riscv_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) begin
        m_pc[k][wp[k][AW-1:0]]    <= i_riscv_trc_pc[k*XLEN +: XLEN];
        m_instr[k][wp[k][AW-1:0]] <= i_riscv_trc_instr[k*32 +: 32];
        m_we[k][wp[k][AW-1:0]]    <= i_riscv_trc_rd_we[k];
        m_addr[k][wp[k][AW-1:0]]  <= i_riscv_trc_rd_addr[k*5 +: 5];
        m_data[k][wp[k][AW-1:0]]  <= i_riscv_trc_rd_data[k*XLEN +: XLEN];
      end
    end
  end
  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
      rr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
      o_riscv_trc_ovf <= '0;
      o_riscv_trc_drop_cnt <= '0;
      o_riscv_trc_halted <= 1'b0;
    end else if (i_riscv_trc_clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
      rr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
      o_riscv_trc_ovf <= '0;
      o_riscv_trc_drop_cnt <= '0;
      o_riscv_trc_halted <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (push[k]) wp[k] <= wp[k] + (AW+1)'(1);
      if (pop) begin
        rp[gnt] <= rp[gnt] + (AW+1)'(1);
        rr <= nxt;
      end
      locked <= o_riscv_trc_valid & ~i_riscv_trc_ready;
      lock_ch <= gnt;
      o_riscv_trc_ovf <= o_riscv_trc_ovf | drop;
      o_riscv_trc_drop_cnt <= cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
      if (i_riscv_trc_halt_en && |hit) o_riscv_trc_halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: directed scenario bench for riscv_trace_buffer.
module tb_riscv_trace_buffer;
  localparam int XLEN = 64, NUM_CH = 5, CNTW = 16;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, trc_clear = 1'b0, halt_en = 1'b0, ready = 1'b0;
  logic [NUM_CH-1:0] valid = '0, rd_we = '0;
  logic [NUM_CH*XLEN-1:0] pc = '0, rd_data = '0;
  logic [NUM_CH*32-1:0] instr = '0;
  logic [NUM_CH*5-1:0] rd_addr = '0;
  logic o_valid, o_rd_we, o_halted;
  logic [2:0] o_ch;
  logic [XLEN-1:0] o_pc, o_rd_data;
  logic [31:0] o_instr;
  logic [4:0] o_rd_addr;
  logic [NUM_CH-1:0] o_ovf;
  logic [CNTW-1:0] o_drop;
  int total = 0, bad = 0;

  riscv_trace_buffer dut (
    .i_riscv_clk(clk), .i_riscv_rst(rst), .i_riscv_trc_clear(trc_clear),
    .i_riscv_trc_halt_en(halt_en), .i_riscv_trc_valid(valid), .i_riscv_trc_pc(pc),
    .i_riscv_trc_instr(instr), .i_riscv_trc_rd_we(rd_we), .i_riscv_trc_rd_addr(rd_addr),
    .i_riscv_trc_rd_data(rd_data), .i_riscv_trc_ready(ready), .o_riscv_trc_valid(o_valid),
    .o_riscv_trc_ch(o_ch), .o_riscv_trc_pc(o_pc), .o_riscv_trc_instr(o_instr),
    .o_riscv_trc_rd_we(o_rd_we), .o_riscv_trc_rd_addr(o_rd_addr), .o_riscv_trc_rd_data(o_rd_data),
    .o_riscv_trc_ovf(o_ovf), .o_riscv_trc_drop_cnt(o_drop), .o_riscv_trc_halted(o_halted)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [63:0] p, input logic [31:0] ins);
    valid[k] = 1'b1;
    pc[k*XLEN +: XLEN] = p;
    instr[k*32 +: 32] = ins;
    rd_we[k] = 1'b1;
    rd_addr[k*5 +: 5] = 5'(k + 1);
    rd_data[k*XLEN +: XLEN] = p ^ 64'hABCD;
  endtask

  task automatic do_clear;
    valid = '0;
    trc_clear = 1'b1;
    step();
    trc_clear = 1'b0;
  endtask

  task automatic test_reset;
    step();
    total++;
    if (o_valid !== 1'b0 || o_ovf !== '0 || o_drop !== '0 || o_halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_init valid=%b ovf=%b drop=%0d halted=%b want all 0", o_valid, o_ovf, o_drop, o_halted);
    end
    rst = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid = '0;
      if (i < 3) set_ch(0, 64'h10 + 64'(4 * i), NOP);
      set_ch(1, 64'h20 + 64'(4 * i), NOP);
      step();
    end
    valid = '0;
    total++;
    if (o_valid !== 1'b1 || o_ovf !== 5'b00010 || o_drop !== 16'd1) begin
      bad++;
      $display("FAIL reset_prefill valid=%b ovf=%b drop=%0d want 1 00010 1", o_valid, o_ovf, o_drop);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_ovf !== '0 || o_drop !== '0 || o_halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_async valid=%b ovf=%b drop=%0d halted=%b want all 0", o_valid, o_ovf, o_drop, o_halted);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = '0;
      set_ch(2, 64'h100 + 64'(4 * i), NOP);
      if (i == 0) begin
        #1;
        total++;
        if (o_valid !== 1'b0) begin
          bad++;
          $display("FAIL single_nobypass valid=%b want 0", o_valid);
        end
      end
      step();
      total++;
      if (o_valid !== 1'b1 || o_ch !== 3'd2 || o_pc !== 64'h100 + 64'(4 * i) ||
          o_rd_data !== ((64'h100 + 64'(4 * i)) ^ 64'hABCD) || o_rd_addr !== 5'd3 ||
          o_rd_we !== 1'b1 || o_instr !== NOP) begin
        bad++;
        $display("FAIL single[%0d] valid=%b ch=%0d pc=%h rd_data=%h rd_addr=%0d want ch=2 pc=%h",
                 i, o_valid, o_ch, o_pc, o_rd_data, o_rd_addr, 64'h100 + 64'(4 * i));
      end
    end
    valid = '0;
    step();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_empty valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] order [3];
    logic [2:0] k;
    order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd4;
    do_clear();
    ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      valid = '0;
      for (int n = 0; n < 3; n++) set_ch(int'(order[n]), 64'h1000 * 64'(order[n] + 3'd1) + 64'(4 * j), NOP);
      step();
    end
    valid = '0;
    ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      k = order[n % 3];
      #1;
      total++;
      if (o_valid !== 1'b1 || o_ch !== k || o_pc !== 64'h1000 * 64'(k + 3'd1) + 64'(4 * (n / 3))) begin
        bad++;
        $display("FAIL rr[%0d] valid=%b ch=%0d pc=%h want ch=%0d pc=%h", n, o_valid, o_ch, o_pc,
                 k, 64'h1000 * 64'(k + 3'd1) + 64'(4 * (n / 3)));
      end
      step();
    end
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_empty valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back;
    ready = 1'b0;
    valid = '0;
    set_ch(3, 64'h200, NOP);
    step();
    valid = '0;
    set_ch(0, 64'h300, NOP);
    set_ch(3, 64'h204, NOP);
    for (int i = 0; i < 5; i++) begin
      step();
      valid = '0;
      total++;
      if (o_valid !== 1'b1 || o_ch !== 3'd3 || o_pc !== 64'h200) begin
        bad++;
        $display("FAIL hold[%0d] valid=%b ch=%0d pc=%h want ch=3 pc=200", i, o_valid, o_ch, o_pc);
      end
    end
    ready = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b1 || o_ch !== 3'd3 || o_pc !== 64'h200) begin
      bad++;
      $display("FAIL hold_accept valid=%b ch=%0d pc=%h want ch=3 pc=200", o_valid, o_ch, o_pc);
    end
    step();
    total++;
    if (o_valid !== 1'b1 || o_ch !== 3'd0 || o_pc !== 64'h300) begin
      bad++;
      $display("FAIL after_hold0 valid=%b ch=%0d pc=%h want ch=0 pc=300", o_valid, o_ch, o_pc);
    end
    step();
    total++;
    if (o_valid !== 1'b1 || o_ch !== 3'd3 || o_pc !== 64'h204) begin
      bad++;
      $display("FAIL after_hold1 valid=%b ch=%0d pc=%h want ch=3 pc=204", o_valid, o_ch, o_pc);
    end
    step();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_empty valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_overflow;
    do_clear();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid = '0;
      set_ch(0, 64'h500 + 64'(4 * i), NOP);
      step();
    end
    valid = '0;
    total++;
    if (o_drop !== 16'd2 || o_ovf !== 5'b00001 || o_valid !== 1'b1 || o_pc !== 64'h500) begin
      bad++;
      $display("FAIL ovf_fill drop=%0d ovf=%b valid=%b pc=%h want 2 00001 1 500", o_drop, o_ovf, o_valid, o_pc);
    end
    ready = 1'b1;
    set_ch(0, 64'h5F0, NOP);
    step();
    valid = '0;
    total++;
    if (o_drop !== 16'd3 || o_ovf !== 5'b00001) begin
      bad++;
      $display("FAIL ovf_pushpop drop=%0d ovf=%b want 3 00001", o_drop, o_ovf);
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (o_valid !== 1'b1 || o_ch !== 3'd0 || o_pc !== 64'h504 + 64'(4 * i)) begin
        bad++;
        $display("FAIL ovf_drain[%0d] valid=%b ch=%0d pc=%h want pc=%h", i, o_valid, o_ch, o_pc, 64'h504 + 64'(4 * i));
      end
      step();
    end
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_empty valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_halt;
    do_clear();
    total++;
    if (o_drop !== '0 || o_ovf !== '0) begin
      bad++;
      $display("FAIL clear_counters drop=%0d ovf=%b want 0 0", o_drop, o_ovf);
    end
    halt_en = 1'b1;
    ready = 1'b0;
    valid = '0;
    set_ch(4, 64'h700, EBREAK);
    set_ch(1, 64'h600, NOP);
    step();
    total++;
    if (o_halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_set halted=%b want 1", o_halted);
    end
    halt_en = 1'b0;
    valid = '0;
    set_ch(1, 64'h610, NOP);
    set_ch(3, 64'h630, NOP);
    step();
    valid = '0;
    total++;
    if (o_halted !== 1'b1 || o_drop !== '0 || o_ovf !== '0) begin
      bad++;
      $display("FAIL halt_ignore halted=%b drop=%0d ovf=%b want 1 0 0", o_halted, o_drop, o_ovf);
    end
    ready = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b1 || o_ch !== 3'd1 || o_pc !== 64'h600) begin
      bad++;
      $display("FAIL halt_drain0 valid=%b ch=%0d pc=%h want ch=1 pc=600", o_valid, o_ch, o_pc);
    end
    step();
    total++;
    if (o_valid !== 1'b1 || o_ch !== 3'd4 || o_pc !== 64'h700 || o_instr !== EBREAK) begin
      bad++;
      $display("FAIL halt_drain1 valid=%b ch=%0d pc=%h instr=%h want ch=4 pc=700 instr=%h", o_valid, o_ch, o_pc, o_instr, EBREAK);
    end
    step();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_empty valid=%b want 0", o_valid);
    end
    do_clear();
    total++;
    if (o_halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_release halted=%b want 0", o_halted);
    end
    valid = '0;
    set_ch(2, 64'h800, EBREAK);
    step();
    valid = '0;
    total++;
    if (o_halted !== 1'b0 || o_valid !== 1'b1 || o_ch !== 3'd2 || o_pc !== 64'h800) begin
      bad++;
      $display("FAIL halt_resume halted=%b valid=%b ch=%0d pc=%h want 0 1 2 800", o_halted, o_valid, o_ch, o_pc);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_overflow();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
